hazard_stall_ctrl: RTL and testbench

HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

---
 rtl/hazard_stall_ctrl_pkg.sv | 26 ++
 rtl/hazard_stall_ctrl_if.sv | 37 +++
 rtl/hazard_stall_ctrl_sat_counter.sv | 20 ++
 rtl/hazard_stall_ctrl.sv | 120 ++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline definitions for the hazard/stall controller: state encoding,
// field widths and the load-use detection rule.
package hazard_stall_ctrl_pkg;

    localparam int REG_W  = 3;
    localparam int CNT_W  = 16;
    localparam int WAIT_W = 8;
    localparam logic [WAIT_W-1:0] WAIT_MAX = 8'd255;

    typedef enum logic {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    // Register 0 is hardwired to zero, so a load targeting it never creates a hazard.
    function automatic logic load_use_hit(
        input logic             memread,
        input logic [REG_W-1:0] rd,
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rt,
        input logic             uses_rt
    );
        return memread && (rd != '0) && ((rd == rs) || (uses_rt && (rd == rt)));
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side bundle of the hazard/stall controller: hazard sources in,
// stall/flush controls and status out.
interface hazard_stall_ctrl_if;
    import hazard_stall_ctrl_pkg::*;

    logic [REG_W-1:0] id_rs_i;
    logic [REG_W-1:0] id_rt_i;
    logic             id_uses_rt_i;
    logic             ex_memread_i;
    logic [REG_W-1:0] ex_rd_i;
    logic             mem_req_i;
    logic             mem_ack_i;
    logic             branch_taken_i;

    logic             pc_stall_o;
    logic             ifid_stall_o;
    logic             exmem_stall_o;
    logic             idex_bubble_o;
    logic             ifid_flush_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic             wait_err_o;

    modport master (
        output id_rs_i, id_rt_i, id_uses_rt_i, ex_memread_i, ex_rd_i,
               mem_req_i, mem_ack_i, branch_taken_i,
        input  pc_stall_o, ifid_stall_o, exmem_stall_o, idex_bubble_o,
               ifid_flush_o, stall_cnt_o, wait_err_o
    );

    modport slave (
        input  id_rs_i, id_rt_i, id_uses_rt_i, ex_memread_i, ex_rd_i,
               mem_req_i, mem_ack_i, branch_taken_i,
        output pc_stall_o, ifid_stall_o, exmem_stall_o, idex_bubble_o,
               ifid_flush_o, stall_cnt_o, wait_err_o
    );

endinterface

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Up-counter with synchronous clear that sticks at its all-ones value.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use bubbles, data-memory wait stalls,
// taken-branch flushes (deferred while memory is pending) and stall statistics.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    hazard_stall_ctrl_if.slave bus
);

    state_t            state;
    logic              branch_pend;
    logic              wait_err;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  stall_cnt;

    logic load_use;
    logic mem_miss;
    logic pc_stall;
    logic ifid_stall;
    logic exmem_stall;
    logic idex_bubble;
    logic ifid_flush;

    assign load_use = load_use_hit(bus.ex_memread_i, bus.ex_rd_i, bus.id_rs_i,
                                   bus.id_rt_i, bus.id_uses_rt_i);
    assign mem_miss = bus.mem_req_i && !bus.mem_ack_i;

    // Memory stall outranks a branch flush, which outranks a load-use bubble.
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        exmem_stall = 1'b0;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        if (!rst_i) begin
            unique case (state)
                IDLE: begin
                    if (mem_miss) begin
                        pc_stall    = 1'b1;
                        ifid_stall  = 1'b1;
                        exmem_stall = 1'b1;
                    end else if (bus.branch_taken_i) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (load_use) begin
                        pc_stall    = 1'b1;
                        ifid_stall  = 1'b1;
                        idex_bubble = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (!bus.mem_ack_i) begin
                        pc_stall    = 1'b1;
                        ifid_stall  = 1'b1;
                        exmem_stall = 1'b1;
                    end else if (branch_pend) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // A branch resolved alongside a stalled access is remembered and
    // flushed once the access completes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            branch_pend <= 1'b0;
            wait_err    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (mem_miss) begin
                        state       <= MEM_WAIT;
                        branch_pend <= bus.branch_taken_i;
                    end
                end
                MEM_WAIT: begin
                    if (wait_cnt == WAIT_MAX) begin
                        wait_err <= 1'b1;
                    end
                    if (bus.mem_ack_i) begin
                        state       <= IDLE;
                        branch_pend <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sat_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .clr   ((state == MEM_WAIT) && bus.mem_ack_i),
        .inc   ((state == MEM_WAIT) && !bus.mem_ack_i),
        .count (wait_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .clr   (1'b0),
        .inc   (pc_stall),
        .count (stall_cnt)
    );

    assign bus.pc_stall_o    = pc_stall;
    assign bus.ifid_stall_o  = ifid_stall;
    assign bus.exmem_stall_o = exmem_stall;
    assign bus.idex_bubble_o = idex_bubble;
    assign bus.ifid_flush_o  = ifid_flush;
    assign bus.stall_cnt_o   = stall_cnt;
    assign bus.wait_err_o    = wait_err;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_hazard_stall_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl_if bus ();

    hazard_stall_ctrl dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Behavioural model state: plain integers/flags describing the pipeline situation.
    bit waiting     = 0;
    bit pending_br  = 0;
    int wait_cycles = 0;
    int stall_total = 0;
    bit err_seen    = 0;

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic apply_stimulus(input int rs, input int rt, input bit uses_rt, input bit memread,
                                  input int rd, input bit req, input bit ack, input bit br);
        bus.id_rs_i        = 3'(rs);
        bus.id_rt_i        = 3'(rt);
        bus.id_uses_rt_i   = uses_rt;
        bus.ex_memread_i   = memread;
        bus.ex_rd_i        = 3'(rd);
        bus.mem_req_i      = req;
        bus.mem_ack_i      = ack;
        bus.branch_taken_i = br;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        apply_stimulus(1, 2, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        next_cycle();
        rst = 1'b0;
    endtask

    // Every negedge: derive required outputs from the rules, compare, then advance the model.
    always @(negedge clk) begin
        bit lu;
        bit e_pc, e_ifid, e_exmem, e_bub, e_flush;
        lu = bus.ex_memread_i && (int'(bus.ex_rd_i) != 0) &&
             ((int'(bus.ex_rd_i) == int'(bus.id_rs_i)) ||
              (bus.id_uses_rt_i && (int'(bus.ex_rd_i) == int'(bus.id_rt_i))));
        {e_pc, e_ifid, e_exmem, e_bub, e_flush} = '0;
        if (!rst) begin
            if (!waiting) begin
                if (bus.mem_req_i && !bus.mem_ack_i) {e_pc, e_ifid, e_exmem} = 3'b111;
                else if (bus.branch_taken_i)         {e_flush, e_bub} = 2'b11;
                else if (lu)                         {e_pc, e_ifid, e_bub} = 3'b111;
            end else begin
                if (!bus.mem_ack_i)   {e_pc, e_ifid, e_exmem} = 3'b111;
                else if (pending_br)  {e_flush, e_bub} = 2'b11;
            end
        end
        check_output("pc_stall",    32'(bus.pc_stall_o),    32'(e_pc));
        check_output("ifid_stall",  32'(bus.ifid_stall_o),  32'(e_ifid));
        check_output("exmem_stall", 32'(bus.exmem_stall_o), 32'(e_exmem));
        check_output("idex_bubble", 32'(bus.idex_bubble_o), 32'(e_bub));
        check_output("ifid_flush",  32'(bus.ifid_flush_o),  32'(e_flush));
        check_output("stall_cnt",   32'(bus.stall_cnt_o),   32'(stall_total));
        check_output("wait_err",    32'(bus.wait_err_o),    32'(err_seen));

        if (rst) begin
            waiting = 0; pending_br = 0; wait_cycles = 0; stall_total = 0; err_seen = 0;
        end else begin
            if (e_pc && stall_total < 65535) stall_total++;
            if (waiting) begin
                if (wait_cycles == 255) err_seen = 1;
                if (bus.mem_ack_i) begin
                    waiting = 0; pending_br = 0; wait_cycles = 0;
                end else if (wait_cycles < 255) begin
                    wait_cycles++;
                end
            end else if (bus.mem_req_i && !bus.mem_ack_i) begin
                waiting = 1;
                pending_br = bus.branch_taken_i;
            end
        end
    end

    initial begin
        idle_inputs();
        next_cycle();
        @(negedge clk);
        check_output("lit_reset_pc", 32'(bus.pc_stall_o), 32'd0);
        check_output("lit_reset_cnt", 32'(bus.stall_cnt_o), 32'd0);
        rst = 1'b0;
        next_cycle();

        // Load-use on rs: one-cycle bubble, then counter shows 1
        apply_stimulus(3, 1, 0, 1, 3, 0, 0, 0);
        @(negedge clk);
        check_output("lit_lu_pc",    32'(bus.pc_stall_o),    32'd1);
        check_output("lit_lu_bub",   32'(bus.idex_bubble_o), 32'd1);
        check_output("lit_lu_exmem", 32'(bus.exmem_stall_o), 32'd0);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check_output("lit_lu_after_pc", 32'(bus.pc_stall_o),  32'd0);
        check_output("lit_lu_cnt",      32'(bus.stall_cnt_o), 32'd1);
        next_cycle();

        apply_stimulus(0, 0, 1, 1, 0, 0, 0, 0);
        @(negedge clk);
        check_output("lit_r0_pc", 32'(bus.pc_stall_o), 32'd0);
        next_cycle();
        apply_stimulus(1, 5, 0, 1, 5, 0, 0, 0);
        @(negedge clk);
        check_output("lit_rt_unused_pc", 32'(bus.pc_stall_o), 32'd0);
        next_cycle();

        // Memory wait: four stall cycles then ack
        do_reset();
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1, 2, 0, 0, 0, 1, (i == 4), 0);
            @(negedge clk);
            check_output("lit_mw_pc",    32'(bus.pc_stall_o),    32'(i != 4));
            check_output("lit_mw_exmem", 32'(bus.exmem_stall_o), 32'(i != 4));
            next_cycle();
        end
        idle_inputs();
        @(negedge clk);
        check_output("lit_mw_cnt", 32'(bus.stall_cnt_o), 32'd4);
        next_cycle();

        // Branch deferred by a memory wait; a branch seen while waiting is ignored
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1, 2, 0, 0, 0, (i < 3), (i == 2), (i < 2));
            @(negedge clk);
            check_output("lit_pb_flush", 32'(bus.ifid_flush_o),  32'(i == 2));
            check_output("lit_pb_bub",   32'(bus.idex_bubble_o), 32'(i == 2));
            next_cycle();
        end

        // Branch beats load-use in IDLE
        apply_stimulus(4, 1, 0, 1, 4, 0, 0, 1);
        @(negedge clk);
        check_output("lit_brlu_flush", 32'(bus.ifid_flush_o), 32'd1);
        check_output("lit_brlu_pc",    32'(bus.pc_stall_o),   32'd0);
        next_cycle();

        // Timeout then reset mid-wait
        do_reset();
        apply_stimulus(1, 2, 0, 0, 0, 1, 0, 0);
        repeat (300) next_cycle();
        @(negedge clk);
        check_output("lit_to_err", 32'(bus.wait_err_o), 32'd1);
        check_output("lit_to_pc",  32'(bus.pc_stall_o), 32'd1);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check_output("lit_rst_pc_forced", 32'(bus.pc_stall_o), 32'd0);
        next_cycle();
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        check_output("lit_rst_err", 32'(bus.wait_err_o),    32'd0);
        check_output("lit_rst_cnt", 32'(bus.stall_cnt_o),   32'd0);
        check_output("lit_rst_pc",  32'(bus.pc_stall_o),    32'd0);
        next_cycle();

        // Randomized traffic checked by the model process
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            apply_stimulus(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           int'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
                           ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
            next_cycle();
        end
        rst = 1'b0;
        idle_inputs();
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
